// File: rtl/timer_master_pkg.sv
// Shared definitions for timer_master: interval-timer register map, control
// bit positions, command encodings and the FSM state set.
package timer_master_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_SNAP  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    GAP,
    WR_CTL,
    WR_STOP,
    WR_SNAP,
    RD_SL,
    RD_SH,
    RD_DONE,
    CLR,
    CLR_W
  } state_e;

  function automatic logic [15:0] ctl_word(input logic stop, input logic start,
                                           input logic cont, input logic ito);
    logic [15:0] w;
    w            = '0;
    w[CTL_STOP]  = stop;
    w[CTL_START] = start;
    w[CTL_CONT]  = cont;
    w[CTL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_master.sv
// Avalon-MM initiator that programs, snapshots and services the interval timer,
// turning each serviced timeout into a tick pulse and a running count.
module timer_master
  import timer_master_pkg::*;
#(
  parameter int unsigned TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq
);

  state_e      state, state_nx;
  logic [31:0] period_q;
  logic        cont_q;
  logic [15:0] snap_lo_q;

  assign cmd_ready = (state == IDLE) && !irq;
  assign busy      = (state != IDLE);
  assign tick      = (state == CLR_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // tick_count steps on the CLR -> CLR_W edge so the new value is visible
  // in the same cycle as the tick pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q   <= '0;
      cont_q     <= 1'b0;
      snap_lo_q  <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
      tick_count <= '0;
    end else begin
      snap_valid <= 1'b0;
      if (cmd_valid && cmd_ready && (op_e'(cmd_op) == OP_START)) begin
        period_q <= cfg_period;
        cont_q   <= cfg_continuous;
      end
      if (state == RD_SH) begin
        snap_lo_q <= m_readdata;
      end
      if (state == RD_DONE) begin
        snap_value <= {m_readdata, snap_lo_q};
        snap_valid <= 1'b1;
      end
      if (state == CLR) begin
        tick_count <= tick_count + TICK_W'(1);
      end
    end
  end

  always_comb begin
    state_nx     = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = ADDR_STATUS;
    m_writedata  = '0;
    case (state)
      IDLE: begin
        if (irq) begin
          state_nx = CLR;
        end else if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_START: state_nx = WR_PL;
            OP_STOP:  state_nx = WR_STOP;
            OP_SNAP:  state_nx = WR_SNAP;
            default:  state_nx = IDLE;
          endcase
        end
      end
      WR_PL: begin
        state_nx     = WR_PH;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIOD_L;
        m_writedata  = period_q[15:0];
      end
      WR_PH: begin
        state_nx     = GAP;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_PERIOD_H;
        m_writedata  = period_q[31:16];
      end
      // Idle bus cycle keeps the control write clear of the timer's
      // force-reload cycle that follows a period write.
      GAP: begin
        state_nx = WR_CTL;
      end
      WR_CTL: begin
        state_nx     = IDLE;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_CONTROL;
        m_writedata  = ctl_word(1'b0, 1'b1, cont_q, 1'b1);
      end
      WR_STOP: begin
        state_nx     = IDLE;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_CONTROL;
        m_writedata  = ctl_word(1'b1, 1'b0, 1'b0, 1'b1);
      end
      WR_SNAP: begin
        state_nx     = RD_SL;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_SNAP_L;
      end
      RD_SL: begin
        state_nx     = RD_SH;
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAP_L;
      end
      RD_SH: begin
        state_nx     = RD_DONE;
        m_chipselect = 1'b1;
        m_address    = ADDR_SNAP_H;
      end
      RD_DONE: begin
        state_nx = IDLE;
      end
      CLR: begin
        state_nx     = CLR_W;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = ADDR_STATUS;
      end
      CLR_W: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_master.sv
// Bench for timer_master: behavioural interval-timer slave, a cycle-schedule
// model of the expected bus/tick/snapshot behaviour, and directed scenarios.
module tb_timer_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b11;
  logic [31:0] cfg_period = '0;
  logic        cfg_continuous = 1'b0;
  logic        cmd_ready, busy, tick, snap_valid;
  logic [31:0] tick_count, snap_value;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata, m_readdata;
  logic        irq;

  always #5 clk = ~clk;

  timer_master #(.TICK_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
    .busy(busy), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq(irq)
  );

  // ---------------- interval timer slave model ----------------
  logic        t_to = 1'b0, t_ito = 1'b0, t_cont = 1'b0, t_run = 1'b0;
  logic [31:0] t_period = '0, t_count = '0, t_snap = '0;
  logic [15:0] t_rdata = '0;
  logic        kick = 1'b0, load_req = 1'b0;
  logic [31:0] load_val = '0;

  assign irq        = t_to & t_ito;
  assign m_readdata = t_rdata;

  function automatic logic [15:0] t_read(input logic [2:0] a);
    case (a)
      3'd0:    return {14'd0, t_run, t_to};
      3'd1:    return {14'd0, t_cont, t_ito};
      3'd2:    return t_period[15:0];
      3'd3:    return t_period[31:16];
      3'd4:    return t_snap[15:0];
      3'd5:    return t_snap[31:16];
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0; t_run <= 1'b0;
      t_period <= '0; t_count <= '0; t_snap <= '0; t_rdata <= '0;
    end else begin
      t_rdata <= t_read(m_address);
      if (load_req) t_count <= load_val;
      if (kick) begin t_to <= 1'b1; t_ito <= 1'b1; end
      if (t_run) begin
        if (t_count == 0) begin
          t_to    <= 1'b1;
          t_count <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_count <= t_count - 1;
        end
      end
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito  <= m_writedata[0];
            t_cont <= m_writedata[1];
            if (m_writedata[2]) begin t_run <= 1'b1; t_count <= t_period; end
            if (m_writedata[3]) t_run <= 1'b0;
          end
          3'd2: t_period[15:0]  <= m_writedata;
          3'd3: t_period[31:16] <= m_writedata;
          3'd4, 3'd5: t_snap <= t_count;
          default: ;
        endcase
      end
    end
  end

  // ---------------- expected-behaviour model ----------------
  // q holds the expected bus cycle for the current cycle and the ones that follow;
  // an empty queue means the initiator is idle.
  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [15:0] d;
    logic        tk;
    logic        cap;
  } ent_t;

  function automatic ent_t mk(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [15:0] d, input logic tk, input logic cap);
    ent_t e;
    e.cs = cs; e.wn = wn; e.a = a; e.d = d; e.tk = tk; e.cap = cap;
    return e;
  endfunction

  ent_t        q[$];
  ent_t        m_e;
  logic [31:0] e_cnt = '0, e_snap = '0;
  logic        e_snapv = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      e_cnt = '0; e_snap = '0; e_snapv = 1'b0;
    end else begin
      e_snapv = 1'b0;
      if (q.size() != 0) begin
        m_e = q.pop_front();
        if (m_e.cap) begin
          e_snapv = 1'b1;
          e_snap  = t_snap;
        end
      end else if (irq) begin
        q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0));
      end else if (cmd_valid) begin
        case (cmd_op)
          2'b00: begin
            q.push_back(mk(1'b1, 1'b0, 3'd2, cfg_period[15:0], 1'b0, 1'b0));
            q.push_back(mk(1'b1, 1'b0, 3'd3, cfg_period[31:16], 1'b0, 1'b0));
            q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0));
            q.push_back(mk(1'b1, 1'b0, 3'd1, cfg_continuous ? 16'h0007 : 16'h0005, 1'b0, 1'b0));
          end
          2'b01: q.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0009, 1'b0, 1'b0));
          2'b10: begin
            q.push_back(mk(1'b1, 1'b0, 3'd4, 16'h0000, 1'b0, 1'b0));
            q.push_back(mk(1'b1, 1'b1, 3'd4, 16'h0000, 1'b0, 1'b0));
            q.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0000, 1'b0, 1'b0));
            q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1));
          end
          default: ;
        endcase
      end
      if (q.size() != 0 && q[0].tk) e_cnt = e_cnt + 1;
    end
  end

  // ---------------- bookkeeping ----------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] c;
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t wlog[$];

  always @(negedge clk) begin
    if (reset_n && m_chipselect && !m_write_n)
      wlog.push_back({cyc, m_address, m_writedata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    ent_t c;
    c = (q.size() != 0) ? q[0] : mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0);
    chk("m_chipselect", 32'(m_chipselect), 32'(c.cs));
    chk("m_write_n",    32'(m_write_n),    32'(c.wn));
    chk("m_address",    32'(m_address),    32'(c.a));
    chk("m_writedata",  32'(m_writedata),  32'(c.d));
    chk("busy",         32'(busy),         32'(q.size() != 0));
    chk("cmd_ready",    32'(cmd_ready),    32'((q.size() == 0) && !irq));
    chk("tick",         32'(tick),         32'(c.tk));
    chk("tick_count",   tick_count,        e_cnt);
    chk("snap_valid",   32'(snap_valid),   32'(e_snapv));
    chk("snap_value",   snap_value,        e_snap);
  endtask

  int unsigned wbase = 0;

  task automatic chk_w(input string name, input int unsigned idx, input int unsigned acc,
                       input int unsigned rel, input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    if (wbase + idx < wlog.size()) begin
      w = wlog[wbase + idx];
      chk(name, {5'd0, 8'(w.c - acc + 1), w.a, w.d}, {5'd0, 8'(rel), a, d});
    end else begin
      chk({name, "_present"}, 32'(wlog.size() - wbase), 32'(idx + 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont,
                        output int unsigned acc);
    logic ok;
    ok = 1'b0;
    cmd_op = op; cfg_period = per; cfg_continuous = cont; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      step();
    end
    cmd_valid = 1'b0; cmd_op = 2'b11;
    chk("cmd_accepted", 32'(ok), 32'd1);
    acc = cyc;
  endtask

  // ---------------- directed scenarios ----------------
  int unsigned A, K, n, lowcnt, nt, nclr, pulses;
  int unsigned tt[5];
  logic        okr;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none

    // reset state
    repeat (3) step();
    chk("rst_tick_count", tick_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_snap_value", snap_value, 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // start, period 0x186A0, continuous
    wbase = wlog.size();
    do_cmd(2'b00, 32'h000186A0, 1'b1, A);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin n = i; break; end
    end
    step();
    chk("start_ready_cycle", n, 32'd5);
    chk_w("start_wr_pl", 0, A, 1, 3'd2, 16'h86A0);
    chk_w("start_wr_ph", 1, A, 2, 3'd3, 16'h0001);
    chk_w("start_wr_ctl", 2, A, 4, 3'd1, 16'h0007);
    wbase = wlog.size();
    do_cmd(2'b01, '0, 1'b0, A);
    repeat (3) step();
    chk_w("stop_wr", 0, A, 1, 3'd1, 16'h0009);

    // snapshot of counter 0xABCD1234
    load_val = 32'hABCD1234; load_req = 1'b1;
    step();
    load_req = 1'b0;
    wbase = wlog.size();
    do_cmd(2'b10, '0, 1'b0, A);
    n = 0; pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (snap_valid) begin
        pulses++;
        if (n == 0) n = i;
      end
    end
    step();
    chk("snap_valid_cycle", n, 32'd5);
    chk("snap_valid_pulses", pulses, 32'd1);
    chk("snap_value_lit", snap_value, 32'hABCD1234);
    chk_w("snap_wr", 0, A, 1, 3'd4, 16'h0000);
    chk("snap_write_count", 32'(wlog.size() - wbase), 32'd1);

    // no-op: accepted, no bus traffic
    wbase = wlog.size();
    do_cmd(2'b11, '0, 1'b0, A);
    repeat (4) step();
    chk("nop_write_count", 32'(wlog.size() - wbase), 32'd0);

    // period 9 continuous against the timer model
    wbase = wlog.size();
    do_cmd(2'b00, 32'd9, 1'b1, A);
    nt = 0;
    for (int i = 0; i < 300 && nt < 5; i++) begin
      @(negedge clk);
      if (tick) begin tt[nt] = cyc; nt++; end
    end
    step();
    chk("p9_tick_count", tick_count, 32'd5);
    for (int k = 1; k < 5; k++) chk("p9_tick_spacing", tt[k] - tt[k-1], 32'd10);
    nclr = 0;
    for (int i = int'(wbase); i < wlog.size(); i++) if (wlog[i].a == 3'd0) nclr++;
    chk("p9_status_writes", nclr, 32'd5);
    do_cmd(2'b01, '0, 1'b0, A);
    repeat (30) step();
    chk("p9_after_stop", tick_count, 32'd5);

    // irq and start in the same cycle
    wbase = wlog.size();
    kick = 1'b1;
    step();
    kick = 1'b0;
    K = cyc;
    cmd_op = 2'b00; cfg_period = 32'd1000; cfg_continuous = 1'b0; cmd_valid = 1'b1;
    lowcnt = 0; okr = 1'b0;
    for (int i = 0; i < 20 && !okr; i++) begin
      @(negedge clk);
      if (cmd_ready) okr = 1'b1; else lowcnt++;
      step();
    end
    cmd_valid = 1'b0; cmd_op = 2'b11;
    chk("irq_ready_low_cycles", lowcnt, 32'd3);
    repeat (6) step();
    chk_w("irq_clr_wr", 0, K, 2, 3'd0, 16'h0000);
    chk_w("irq_start_pl", 1, K, 5, 3'd2, 16'h03E8);
    chk_w("irq_start_ph", 2, K, 6, 3'd3, 16'h0000);
    chk_w("irq_start_ctl", 3, K, 8, 3'd1, 16'h0005);
    chk("irq_tick_count", tick_count, 32'd6);
    do_cmd(2'b01, '0, 1'b0, A);
    repeat (3) step();

    // one-shot period 4, then stop
    do_cmd(2'b00, 32'd4, 1'b0, A);
    nt = 0;
    for (int i = 0; i < 100 && nt < 1; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    step();
    wbase = wlog.size();
    do_cmd(2'b01, '0, 1'b0, A);
    repeat (40) step();
    chk_w("os_stop_wr", 0, A, 1, 3'd1, 16'h0009);
    chk("os_tick_count", tick_count, 32'd7);
    chk("os_irq_quiet", 32'(irq), 32'd0);

    // reset asserted in GAP of a start
    do_cmd(2'b00, 32'd50, 1'b1, A);
    step();
    step();
    chk("gap_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_gap_cs", 32'(m_chipselect), 32'd0);
    chk("rst_gap_write_n", 32'(m_write_n), 32'd1);
    chk("rst_gap_busy", 32'(busy), 32'd0);
    chk("rst_gap_tick_count", tick_count, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    do_cmd(2'b00, 32'd9, 1'b1, A);
    nt = 0;
    for (int i = 0; i < 100 && nt < 1; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    step();
    chk("post_rst_tick_count", tick_count, 32'd1);
    do_cmd(2'b01, '0, 1'b0, A);
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
